wash_control_panel: RTL and testbench
=====================================

Name: wash_control_panel

Overview:
User-facing front end that drives the Washing_Machine control inputs and consumes its status.
- Debounces the panel buttons and latches the program selection.
- Issues the start request, toggles pause, and shows a remaining-time countdown.
- Sounds a buzzer when the machine reports done.
- Sits between the panel I/O and Washing_Machine, on the same 1 Hz clock: one cycle = one second.

Parameters:
DEBOUNCE_CYCLES, 2, consecutive stable synchronized samples required to accept a button level
ARM_TIMEOUT, 4, cycles to wait for phase to leave IDLE after start before flagging fault
BUZZ_CYCLES, 5, cycles buzzer stays high after done rises
T_FILL, 10 / T_WASH, 50 / T_RINSE, 50 / T_SPIN, 20 / T_DRY, 60 / T_STEAM, 60: phase durations in seconds

Ports:
clk  in  1  system clock, 1 Hz
rst_n  in  1  asynchronous active-low reset
btn_start  in  1  raw start button, active high, asynchronous
btn_pause  in  1  raw pause button, active high, asynchronous
sw_double  in  1  double-wash selector switch
sw_dry  in  1  dry-wash (steam clean) selector switch
phase  in  3  Washing_Machine current_state code
done  in  1  Washing_Machine done
start  out  1  start request to machine
double_wash  out  1  latched double-wash option
dry_wash  out  1  latched dry-wash option
time_pause  out  1  pause request to machine
remaining_s  out  9  seconds remaining, max 290
buzzer  out  1  end-of-cycle alert
fault  out  1  sticky: machine did not accept start

Behaviour:
- Reset (async, rst_n=0): every output 0, FSM to P_IDLE, debouncers cleared, counters 0. Reset mid-run returns to P_IDLE immediately; no output glitches high.
- Buttons: 2-flop synchronizer, then debounce. A level is accepted after DEBOUNCE_CYCLES identical samples. Action fires on the accepted rising edge only, as a one-cycle press event.
- FSM states: P_IDLE, P_ARMED, P_RUNNING, P_FINISHED.
- P_IDLE:
  - On start press: latch double_wash=sw_double and dry_wash=sw_dry, set start=1, go to P_ARMED, clear fault.
  - Pause presses are ignored.
- P_ARMED:
  - start held at 1.
  - If phase != IDLE (3'b000): go to P_RUNNING, start=0, load remaining_s:
    - 60 if dry_wash;
    - else 290 if double_wash;
    - else 190.
    - dry_wash has priority.
  - If ARM_TIMEOUT cycles elapse with phase still IDLE: start=0, fault=1, options cleared, go to P_IDLE.
- P_RUNNING:
  - A pause press toggles time_pause.
  - Each cycle with time_pause=0: remaining_s decrements, saturating at 0 (never wraps).
  - A start press is ignored.
  - On done=1 or phase==IDLE: time_pause=0, remaining_s=0, go to P_FINISHED with buzzer=1.
- P_FINISHED:
  - buzzer held BUZZ_CYCLES cycles, then 0. double_wash and dry_wash clear on entry.
  - A start press (any time) re-arms exactly as from P_IDLE and clears buzzer the same cycle. The machine clears done when start rises.
  - After the buzzer expires, go to P_IDLE.
- Simultaneous pause and done in the same cycle: done wins, time_pause=0.
- Option switches changing mid-run have no effect; the outputs stay latched.
- Latency:
  - button edge to start=1: 2 sync + DEBOUNCE_CYCLES + 1 registered cycle = 5 cycles at default.
  - done to buzzer: 1 cycle.

Decomposition:
- Shared package wash_pkg holds:
  - phase codes: IDLE=0, FILL_WATER=1, WASH=2, RINSE=3, SPIN=4, DRY=5, STEAM_CLEAN=6;
  - default phase-duration constants;
  - panel state enum.
- Totals (190/290/60) are computed as constant expressions from the duration parameters, not hard-coded.
- Sub-module btn_sync_debounce (synchronizer, debounce counter, rise-event output), instantiated twice.

Test Plan:
1. rst_n=0 while btn_start=1 for 10 cycles -> start=0, all outputs 0, FSM P_IDLE.
2. sw_double=0, sw_dry=0, btn_start high 3 cycles; bench model sets phase=1 two cycles after start -> start=1 within 5 cycles, then 0; remaining_s=190, decrementing 1/cycle.
3. sw_dry=1, sw_double=1, start press -> dry_wash=1, double_wash=1, remaining_s=60 (dry priority). Flip switches mid-run -> outputs unchanged.
4. Running at remaining_s=150: pause press -> time_pause=1, remaining_s frozen at 150 for 30 cycles. Second press -> time_pause=0, decrement resumes.
5. done rises at remaining_s=3 -> next cycle remaining_s=0, buzzer=1 for 5 cycles, options cleared. Start press during buzzer -> buzzer=0 and start=1 the same cycle.
6. Start press with phase held at 0 -> after 4 cycles in P_ARMED: start=0, fault=1, P_IDLE. Next valid start clears fault.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine control panel: machine phase
// codes, default phase durations, panel state encoding and program totals.
package wash_pkg;

  // Washing_Machine current_state codes
  localparam logic [2:0] PH_IDLE        = 3'd0;
  localparam logic [2:0] PH_FILL_WATER  = 3'd1;
  localparam logic [2:0] PH_WASH        = 3'd2;
  localparam logic [2:0] PH_RINSE       = 3'd3;
  localparam logic [2:0] PH_SPIN        = 3'd4;
  localparam logic [2:0] PH_DRY         = 3'd5;
  localparam logic [2:0] PH_STEAM_CLEAN = 3'd6;

  // Default phase durations in seconds (one clock = one second)
  localparam int T_FILL_DEF  = 10;
  localparam int T_WASH_DEF  = 50;
  localparam int T_RINSE_DEF = 50;
  localparam int T_SPIN_DEF  = 20;
  localparam int T_DRY_DEF   = 60;
  localparam int T_STEAM_DEF = 60;

  typedef enum logic [1:0] {
    P_IDLE,
    P_ARMED,
    P_RUNNING,
    P_FINISHED
  } panel_state_t;

  // Normal program: one pass through every phase ending in a dry
  function automatic int normal_total(input int fill, input int wash, input int rinse,
                                      input int spin, input int dry);
    return fill + wash + rinse + spin + dry;
  endfunction

  // Double program repeats the wash and rinse phases
  function automatic int double_total(input int fill, input int wash, input int rinse,
                                      input int spin, input int dry);
    return fill + 2 * (wash + rinse) + spin + dry;
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Button front end: two-flop synchronizer, stability counter, and a
// one-cycle press pulse on the accepted rising edge.
module btn_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Bring the raw asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
    end
  end

  // Count consecutive samples that disagree with the accepted level; flip
  // the level once enough agree, pulsing press only when it flips to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      press <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync;
        press <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wash_control_panel.sv
// Panel front end for Washing_Machine: debounced buttons, program latch,
// start handshake with arm timeout, pause toggle, countdown and buzzer.
module wash_control_panel
  import wash_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int ARM_TIMEOUT     = 4,
  parameter int BUZZ_CYCLES     = 5,
  parameter int T_FILL          = T_FILL_DEF,
  parameter int T_WASH          = T_WASH_DEF,
  parameter int T_RINSE         = T_RINSE_DEF,
  parameter int T_SPIN          = T_SPIN_DEF,
  parameter int T_DRY           = T_DRY_DEF,
  parameter int T_STEAM         = T_STEAM_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       sw_double,
  input  logic       sw_dry,
  input  logic [2:0] phase,
  input  logic       done,
  output logic       start,
  output logic       double_wash,
  output logic       dry_wash,
  output logic       time_pause,
  output logic [8:0] remaining_s,
  output logic       buzzer,
  output logic       fault
);

  localparam logic [8:0] TOTAL_NORMAL = 9'(normal_total(T_FILL, T_WASH, T_RINSE, T_SPIN, T_DRY));
  localparam logic [8:0] TOTAL_DOUBLE = 9'(double_total(T_FILL, T_WASH, T_RINSE, T_SPIN, T_DRY));
  localparam logic [8:0] TOTAL_STEAM  = 9'(T_STEAM);
  localparam logic [7:0] ARM_LAST     = 8'(ARM_TIMEOUT - 1);
  localparam logic [7:0] BUZZ_LAST    = 8'(BUZZ_CYCLES - 1);

  panel_state_t state;
  logic         start_press;
  logic         pause_press;
  logic [7:0]   arm_cnt;
  logic [7:0]   buzz_cnt;

  btn_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_start),
    .press (start_press)
  );

  btn_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_pause),
    .press (pause_press)
  );

  // Panel FSM; every output is a register so nothing glitches out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= P_IDLE;
      start       <= 1'b0;
      double_wash <= 1'b0;
      dry_wash    <= 1'b0;
      time_pause  <= 1'b0;
      remaining_s <= '0;
      buzzer      <= 1'b0;
      fault       <= 1'b0;
      arm_cnt     <= '0;
      buzz_cnt    <= '0;
    end else begin
      case (state)
        P_IDLE: begin
          if (start_press) begin
            double_wash <= sw_double;
            dry_wash    <= sw_dry;
            start       <= 1'b1;
            fault       <= 1'b0;
            arm_cnt     <= '0;
            state       <= P_ARMED;
          end
        end
        P_ARMED: begin
          // Machine leaving IDLE is the acknowledge; steam program wins
          if (phase != PH_IDLE) begin
            start       <= 1'b0;
            remaining_s <= dry_wash    ? TOTAL_STEAM  :
                           double_wash ? TOTAL_DOUBLE : TOTAL_NORMAL;
            state       <= P_RUNNING;
          end else if (arm_cnt == ARM_LAST) begin
            start       <= 1'b0;
            fault       <= 1'b1;
            double_wash <= 1'b0;
            dry_wash    <= 1'b0;
            state       <= P_IDLE;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        P_RUNNING: begin
          // Completion beats a same-cycle pause press
          if (done || phase == PH_IDLE) begin
            time_pause  <= 1'b0;
            remaining_s <= '0;
            buzzer      <= 1'b1;
            buzz_cnt    <= '0;
            double_wash <= 1'b0;
            dry_wash    <= 1'b0;
            state       <= P_FINISHED;
          end else begin
            if (pause_press) time_pause <= ~time_pause;
            if (!time_pause && remaining_s != '0) remaining_s <= remaining_s - 1'b1;
          end
        end
        P_FINISHED: begin
          if (start_press) begin
            double_wash <= sw_double;
            dry_wash    <= sw_dry;
            start       <= 1'b1;
            fault       <= 1'b0;
            buzzer      <= 1'b0;
            arm_cnt     <= '0;
            state       <= P_ARMED;
          end else if (buzz_cnt == BUZZ_LAST) begin
            buzzer <= 1'b0;
            state  <= P_IDLE;
          end else begin
            buzz_cnt <= buzz_cnt + 1'b1;
          end
        end
        default: state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wash_control_panel.sv
// Randomized scoreboard bench for wash_control_panel. A reference model
// advances on every clock edge and queues the expected panel outputs; a
// monitor on the falling edge pops and compares against the DUT.
module tb_wash_control_panel;

  localparam int DEB        = 2;
  localparam int ARM_TO     = 4;
  localparam int BUZZ       = 5;
  localparam int RUN_NORMAL = 10 + 50 + 50 + 20 + 60;
  localparam int RUN_DOUBLE = RUN_NORMAL + 50 + 50;
  localparam int RUN_STEAM  = 60;

  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

  typedef struct packed {
    logic       start;
    logic       double_wash;
    logic       dry_wash;
    logic       time_pause;
    logic [8:0] remaining_s;
    logic       buzzer;
    logic       fault;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_pause = 1'b0, sw_double = 1'b0, sw_dry = 1'b0;
  logic [2:0] phase = 3'd0;
  logic       done = 1'b0;
  logic       start, double_wash, dry_wash, time_pause, buzzer, fault;
  logic [8:0] remaining_s;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];

  // reference model state
  int m_mode, m_rem, m_armed, m_buzz_left;
  bit m_start, m_dbl, m_dry, m_pause, m_buzz, m_fault;
  bit m_acc_s, m_acc_p, m_press_s, m_press_p;
  bit hs[$], hp[$];

  wash_control_panel dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .sw_double   (sw_double),
    .sw_dry      (sw_dry),
    .phase       (phase),
    .done        (done),
    .start       (start),
    .double_wash (double_wash),
    .dry_wash    (dry_wash),
    .time_pause  (time_pause),
    .remaining_s (remaining_s),
    .buzzer      (buzzer),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    obs_t o;
    o = {start, double_wash, dry_wash, time_pause, remaining_s, buzzer, fault};
    return o;
  endfunction

  function automatic void report(input string name, input obs_t got, input obs_t exp);
    $display("FAIL %s @%0t: got start=%0b dbl=%0b dry=%0b pause=%0b rem=%0d buzz=%0b fault=%0b; expected start=%0b dbl=%0b dry=%0b pause=%0b rem=%0d buzz=%0b fault=%0b",
             name, $time, got.start, got.double_wash, got.dry_wash, got.time_pause,
             got.remaining_s, got.buzzer, got.fault, exp.start, exp.double_wash,
             exp.dry_wash, exp.time_pause, exp.remaining_s, exp.buzzer, exp.fault);
  endfunction

  // A button level is taken once the last DEB synchronized samples all
  // disagree with the accepted level; the synchronizer delays by two samples.
  function automatic bit settled(input bit h[$], input bit acc);
    int n;
    n = h.size();
    for (int i = 0; i < DEB; i++)
      if (h[n - 3 - i] == acc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_rem = 0; m_armed = 0; m_buzz_left = 0;
    m_start = 0; m_dbl = 0; m_dry = 0; m_pause = 0; m_buzz = 0; m_fault = 0;
    m_acc_s = 0; m_acc_p = 0; m_press_s = 0; m_press_p = 0;
    hs = '{0, 0, 0, 0};
    hp = '{0, 0, 0, 0};
  endtask

  task automatic m_push();
    obs_t o;
    o.start = m_start; o.double_wash = m_dbl; o.dry_wash = m_dry;
    o.time_pause = m_pause; o.remaining_s = 9'(m_rem);
    o.buzzer = m_buzz; o.fault = m_fault;
    exp_q.push_back(o);
  endtask

  task automatic m_arm();
    m_dbl = sw_double; m_dry = sw_dry; m_start = 1; m_fault = 0;
    m_armed = 0; m_mode = M_ARMED;
  endtask

  task automatic model_step();
    bit ps, pp;
    ps = m_press_s;
    pp = m_press_p;
    hs.push_back(btn_start);
    hp.push_back(btn_pause);
    if (hs.size() > 12) begin hs.delete(0); hp.delete(0); end
    m_press_s = 0;
    m_press_p = 0;
    if (settled(hs, m_acc_s)) begin m_acc_s = !m_acc_s; m_press_s = m_acc_s; end
    if (settled(hp, m_acc_p)) begin m_acc_p = !m_acc_p; m_press_p = m_acc_p; end
    case (m_mode)
      M_IDLE: if (ps) m_arm();
      M_ARMED: begin
        m_armed++;
        if (phase != 3'd0) begin
          m_start = 0;
          m_rem = m_dry ? RUN_STEAM : (m_dbl ? RUN_DOUBLE : RUN_NORMAL);
          m_mode = M_RUN;
        end else if (m_armed >= ARM_TO) begin
          m_start = 0; m_fault = 1; m_dbl = 0; m_dry = 0; m_mode = M_IDLE;
        end
      end
      M_RUN: begin
        if (done || phase == 3'd0) begin
          m_pause = 0; m_rem = 0; m_buzz = 1; m_buzz_left = BUZZ;
          m_dbl = 0; m_dry = 0; m_mode = M_DONE;
        end else begin
          if (!m_pause && m_rem > 0) m_rem--;
          if (pp) m_pause = !m_pause;
        end
      end
      default: begin
        if (ps) begin
          m_arm();
          m_buzz = 0;
        end else begin
          m_buzz_left--;
          if (m_buzz_left == 0) begin m_buzz = 0; m_mode = M_IDLE; end
        end
      end
    endcase
    m_push();
  endtask

  // Reference model advances with the DUT on every rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      model_step();
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the queued expectation
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_obs();
      checks++;
      if (a !== e) begin
        errors++;
        report("panel_outputs", a, e);
      end
    end
  end

  // ---------------- stimulus helpers (aligned 2 units after a rising edge)
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_start(input int len);
    btn_start = 1; cyc(len); btn_start = 0;
  endtask

  task automatic press_pause(input int len);
    btn_pause = 1; cyc(len); btn_pause = 0;
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got timeout, expected event", name);
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    while (!m_start && k < 12) begin cyc(1); k++; end
    if (!m_start) bound_fail("start_wait");
  endtask

  // Emulated machine: acknowledge start two cycles after it rises
  task automatic machine_accept();
    wait_start();
    cyc(2);
    phase = 3'd1;
    done = 0;
  endtask

  task automatic run_phases(input int n);
    repeat (n) begin
      phase = 3'($urandom_range(1, 6));
      cyc(1);
    end
  endtask

  task automatic run_until_rem(input int target);
    int k;
    k = 0;
    while (m_rem != target && k < 400) begin
      phase = 3'($urandom_range(1, 6));
      cyc(1);
      k++;
    end
    if (m_rem != target) bound_fail("countdown_wait");
  endtask

  task automatic machine_finish();
    done = 1; cyc(1);
    phase = 3'd0; cyc(2);
    done = 0;
  endtask

  task automatic async_reset(input int n);
    obs_t a;
    rst_n = 0;
    model_reset();
    exp_q.delete();
    exp_q.push_back('0);
    #1;
    a = dut_obs();
    checks++;
    if (a !== obs_t'(0)) begin
      errors++;
      report("async_reset", a, obs_t'(0));
    end
    cyc(n);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    // reset held with start pressed: nothing may leak out
    btn_start = 1;
    cyc(10);
    btn_start = 0;
    cyc(1);
    rst_n = 1;
    cyc(2);

    // normal program, countdown from 190
    sw_double = 0; sw_dry = 0;
    press_start(3);
    machine_accept();
    run_phases(20);
    machine_finish();
    cyc(8);

    // both switches: steam wins; switch flips mid-run are ignored
    sw_double = 1; sw_dry = 1;
    press_start(3);
    machine_accept();
    run_phases(10);
    sw_double = 0; sw_dry = 0;
    run_phases(10);
    machine_finish();
    cyc(8);

    // pause freeze, resume, then done near the end with a re-arm on the buzzer
    press_start(4);
    machine_accept();
    run_until_rem(152);
    press_pause(3);
    run_phases(30);
    press_pause(2);
    run_until_rem(3);
    done = 1;
    btn_start = 1;
    cyc(1);
    phase = 3'd0;
    cyc(2);
    btn_start = 0;
    wait_start();
    done = 0;
    cyc(2);
    phase = 3'd1;
    run_phases(12);
    async_reset(3);
    phase = 3'd0;
    cyc(3);

    // arm timeout with a silent machine, then a good start clears fault
    press_start(3);
    cyc(12);
    press_start(3);
    machine_accept();
    run_phases(6);
    machine_finish();
    cyc(8);

    // pause pressed right as the machine reports done
    press_start(3);
    machine_accept();
    run_phases(5);
    btn_pause = 1;
    run_phases(3);
    done = 1;
    cyc(1);
    btn_pause = 0;
    phase = 3'd0;
    cyc(2);
    done = 0;
    cyc(8);

    // random soak
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 3) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 15) == 0) sw_double = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) sw_dry = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        phase = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 6));
      done = ($urandom_range(0, 29) == 0);
      if (i == 250) async_reset(2);
      cyc(1);
    end
    btn_start = 0; btn_pause = 0; done = 0;
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
